// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode handshake: head of the fetch queue and decode's accept.
interface inst_fetch_queue_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  modport master (output if_valid, output if_pc, output if_inst, input id_ready);
  modport slave  (input if_valid, input if_pc, input if_inst, output id_ready);
endinterface

// File: rtl/inst_fetch_queue.sv
// PC generator and small {pc, instruction} FIFO between the instruction ROM and decode.
// Redirects flush the queue and reload the PC; fetch halts once the PC leaves the ROM.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned IROM_SPACE = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  output logic [31:0]                inst_addr,
  input  logic [31:0]                inst_i,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  inst_fetch_queue_if.master         dec,
  output logic                       fetch_oob
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  fetch_entry_t     mem [DEPTH];
  logic [31:0]      pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic oob_c;
  logic pop_c;
  logic push_c;

  // 33-bit compare so a PC near the top of the address space cannot wrap into range
  assign oob_c  = ({1'b0, pc} + 33'd3) >= 33'(IROM_SPACE);
  assign pop_c  = (count != '0) && dec.id_ready;
  assign push_c = !redirect_valid && !oob_c && ((count < CNT_W'(DEPTH)) || pop_c);

  assign inst_addr    = pc;
  assign dec.if_valid = (count != '0);
  assign dec.if_pc    = mem[rd_ptr].pc;
  assign dec.if_inst  = mem[rd_ptr].inst;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc        <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fetch_oob <= 1'b0;
      // cleared so the head outputs are never X after reset
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fetch_oob <= 1'b0;
    end else begin
      fetch_oob <= oob_c;
      if (push_c) begin
        mem[wr_ptr] <= {pc, inst_i};
        wr_ptr      <= wr_ptr + PTR_W'(1);
        pc          <= pc + 32'd4;
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      count <= count + CNT_W'(1);
      else if (pop_c && !push_c) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: queue-based scoreboard plus directed checks.
module tb_inst_fetch_queue;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned DEPTH      = 2;
  localparam int unsigned IROM_SPACE = 1024;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] inst_addr;
  logic [31:0] inst_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_oob;

  inst_fetch_queue_if bus ();

  inst_fetch_queue #(
    .RESET_PC  (RESET_PC),
    .DEPTH     (DEPTH),
    .IROM_SPACE(IROM_SPACE)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .inst_addr     (inst_addr),
    .inst_i        (inst_i),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec           (bus.master),
    .fetch_oob     (fetch_oob)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  assign inst_i = rom(inst_addr);

  int checks   = 0;
  int failures = 0;

  // Reference state: expected PC register, halt flag and queued PCs in order
  logic [31:0] m_pc;
  logic        m_oob;
  logic [31:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare outputs with the model, then advance model and DUT one clock
  task automatic cycle();
    logic        oob;
    logic        pop;
    logic        push;
    logic [31:0] hp;
    chk("inst_addr", inst_addr, m_pc);
    chk("if_valid", 32'(bus.if_valid), 32'(m_q.size() != 0));
    chk("fetch_oob", 32'(fetch_oob), 32'(m_oob));
    if (!rstn) begin
      m_pc  = RESET_PC;
      m_oob = 1'b0;
      m_q.delete();
    end else if (redirect_valid) begin
      m_pc  = redirect_pc & 32'hFFFF_FFFC;
      m_oob = 1'b0;
      m_q.delete();
    end else begin
      oob  = ({1'b0, m_pc} + 33'd3) >= 33'(IROM_SPACE);
      pop  = (m_q.size() != 0) && bus.id_ready;
      push = !oob && ((m_q.size() < int'(DEPTH)) || pop);
      if (pop) begin
        hp = m_q.pop_front();
        chk("pop_pc", bus.if_pc, hp);
        chk("pop_inst", bus.if_inst, rom(hp));
      end
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      m_oob = oob;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
  endtask

  initial begin
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.id_ready   = 1'b1;
    m_pc           = RESET_PC;
    m_oob          = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_addr", inst_addr, RESET_PC);
    chk("rst_oob", 32'(fetch_oob), 32'd0);
    chk("rst_head_nox", 32'($isunknown({bus.if_pc, bus.if_inst})), 32'd0);

    // Streaming with decode always ready
    rstn = 1'b1;
    cycle();
    chk("stream_first_valid", 32'(bus.if_valid), 32'd1);
    chk("stream_first_pc", bus.if_pc, 32'h0);
    cycle();
    chk("stream_second_pc", bus.if_pc, 32'h4);
    run(6);

    // Backpressure from reset: queue fills, PC stalls at 8
    do_reset();
    bus.id_ready = 1'b0;
    run(2);
    chk("bp_addr", inst_addr, 32'h8);
    chk("bp_head", bus.if_pc, 32'h0);
    run(3);
    chk("bp_addr_hold", inst_addr, 32'h8);
    chk("bp_head_hold", bus.if_inst, rom(32'h0));
    bus.id_ready = 1'b1;
    run(6);

    // Redirect with two entries queued
    bus.id_ready = 1'b0;
    run(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    cycle();
    redirect_valid = 1'b0;
    chk("redir_valid_low", 32'(bus.if_valid), 32'd0);
    chk("redir_addr", inst_addr, 32'h100);
    bus.id_ready = 1'b1;
    cycle();
    chk("redir_head", bus.if_pc, 32'h100);
    run(3);

    // Back-to-back redirects: the last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cycle();
    redirect_pc    = 32'h83;
    cycle();
    redirect_valid = 1'b0;
    chk("b2b_addr", inst_addr, 32'h80);
    run(3);

    // Last ROM word, then out-of-bounds halt and recovery
    redirect_valid = 1'b1;
    redirect_pc    = IROM_SPACE - 4;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("oob_last_pc", bus.if_pc, 32'h3FC);
    run(3);
    chk("oob_flag", 32'(fetch_oob), 32'd1);
    chk("oob_addr", inst_addr, 32'h400);
    chk("oob_drained", 32'(bus.if_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cycle();
    redirect_valid = 1'b0;
    chk("oob_cleared", 32'(fetch_oob), 32'd0);
    run(4);

    // Redirect far beyond the ROM halts immediately
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    cycle();
    redirect_valid = 1'b0;
    run(3);
    chk("oob_top_addr", inst_addr, 32'hFFFF_FFFC);

    // Reset while full and mid-redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cycle();
    redirect_valid = 1'b0;
    bus.id_ready   = 1'b0;
    run(3);
    rstn           = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    rstn           = 1'b1;
    redirect_valid = 1'b0;
    chk("rst_mid_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_mid_addr", inst_addr, RESET_PC);
    chk("rst_mid_oob", 32'(fetch_oob), 32'd0);
    bus.id_ready = 1'b1;
    run(4);

    // Random traffic with occasional redirects, some near the ROM end
    for (int i = 0; i < 300; i++) begin
      bus.id_ready   = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) redirect_pc = 32'(IROM_SPACE) - 32'($urandom_range(1, 24));
      else redirect_pc = 32'($urandom_range(0, IROM_SPACE - 1));
      cycle();
    end
    redirect_valid = 1'b0;
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- PC generator and fetch buffer sitting directly in front of the byte-addressed instruction ROM.
- Drives the ROM address and captures the 32-bit word the ROM returns combinationally in the same cycle.
- Queues {pc, instruction} pairs in a small FIFO and hands them to the decode stage over a valid/ready handshake.
- Accepts redirects from execute (branch/jump) that flush the queue and reload the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; must be 4-byte aligned.
- DEPTH, 2, FIFO entries; power of two, from 2 to 8.
- IROM_SPACE, 1024, instruction ROM size in bytes; fetch never issues an address with pc+3 >= IROM_SPACE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  synchronous active-low reset.
- inst_addr  output  32  byte address to the ROM; equals the pc register (combinational from the register).
- inst_i  input  32  ROM word for inst_addr, valid in the same cycle.
- redirect_valid  input  1  flush and reload the PC.
- redirect_pc  input  32  new PC; bits [1:0] are forced to 0 on load.
- if_valid  output  1  FIFO head is valid.
- if_pc  output  32  PC of the FIFO head.
- if_inst  output  32  instruction of the FIFO head.
- id_ready  input  1  decode accepts the head this cycle.
- fetch_oob  output  1  registered; PC is outside the ROM and fetch is halted.

Behaviour:
- Reset (rstn=0 at a clock edge): pc=RESET_PC, FIFO empty, count=0, rd/wr pointers=0, fetch_oob=0.
  - Outputs after reset: if_valid=0; if_pc and if_inst are don't-care but must not be X.
  - Reset takes priority over every other input, including mid-stream with a full FIFO.
- pop = if_valid & id_ready.
- push = !redirect_valid & !oob_now & (count<DEPTH | pop).
  - oob_now = (pc + 3 >= IROM_SPACE), compared in 33-bit arithmetic so pc near 2^32 does not wrap.
- On push: write {pc, inst_i} at wr_ptr, wr_ptr++, pc <= pc+4.
  - pc+4 is 32-bit and wraps, but the oob check halts fetch before any wrap occurs.
- On pop: rd_ptr++.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Push while full is legal only together with a pop; the pushed entry lands in the slot being vacated.
- Head outputs: if_valid = (count != 0); if_pc and if_inst are driven combinationally from the entry at rd_ptr.
- Fetch latency: a word appears at the head on the cycle after its pc is presented on inst_addr (queue-through, no bypass).
  - Sustained throughput is 1 instruction per cycle when id_ready is held at 1.
- Redirect (redirect_valid=1):
  - Same edge: FIFO cleared (count=0, pointers=0), pc <= {redirect_pc[31:2], 2'b00}, fetch_oob <= 0.
  - No push that cycle; any pop that cycle is ignored.
  - if_valid=0 on the following cycle; the first redirected instruction is valid the cycle after that.
  - Back-to-back redirects: the last one wins.
- Out-of-bounds: fetch_oob <= oob_now on every cycle with no redirect.
  - While oob_now is true, pc holds and no push occurs; existing entries still drain normally.
  - Only a redirect or reset clears the halt.
- Backpressure: with id_ready=0 and the FIFO full, pc and inst_addr stay stable and the head entry is held unchanged.

Test Plan:
- Reset then id_ready=1, ROM words W0..W3 at byte 0..15 -> if_valid rises one cycle after reset release; if_pc sequence 0,4,8,12 on consecutive cycles with if_inst W0..W3.
- id_ready=0 from reset, DEPTH=2 -> after 2 cycles count=2, inst_addr holds 8, head stays pc=0; raising id_ready gives pc 0,4,8 on consecutive cycles with no gaps or duplicates.
- Full FIFO with id_ready=1 held -> push and pop occur on the same edge; count stays 2; the order 0,4,8,12 is preserved.
- Redirect to 0x0000_0102 while 2 entries are queued -> next cycle if_valid=0 and inst_addr=0x100; following cycle if_pc=0x100.
- Redirect to IROM_SPACE-4 (0x3FC), id_ready=1 -> one entry with pc 0x3FC; then fetch_oob=1, pc holds at 0x400, if_valid drops after the drain; redirect to 0 clears fetch_oob and resumes.
- rstn=0 for one edge while full and mid-redirect -> count=0, pc=RESET_PC, fetch_oob=0; normal fetch from RESET_PC follows.
